// File: rtl/systolic_pkg.sv
// Shared types and sizing helpers for the systolic array sequencer.
// The FSM, skew selector and bench all agree on these defaults.
package systolic_pkg;

  localparam int N_DEF        = 8;
  localparam int K_DEF        = 8;
  localparam int FLUSH_DEF    = 16;
  localparam int READ_LAT_DEF = 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CLEAR,
    S_FEED,
    S_FLUSH,
    S_READ,
    S_DRAIN
  } state_t;

  // The array shifts out its bottom row (C_{N-1}) first, so capture order equals slot order.
  localparam bit READOUT_LAST_ROW_FIRST = 1'b1;

  function automatic int beat_width(input int n, input int k, input int flush, input int read_lat);
    int m;
    m = 2 * k;
    if (k + n - 1 > m) m = k + n - 1;
    if (flush > m) m = flush;
    if (read_lat + n > m) m = read_lat + n;
    return $clog2(m + 1);
  endfunction

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/systolic_skew.sv
// Combinational diagonal skew: on beat t, bit j of each wavefront carries
// operand t-j, so lane j lags lane 0 by j cycles.
module systolic_skew
  import systolic_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int K  = K_DEF,
  parameter int CW = beat_width(N_DEF, K_DEF, FLUSH_DEF, READ_LAT_DEF)
) (
  input  logic                  feed_en,
  input  logic [CW-1:0]         beat,
  input  logic [K-1:0][N-1:0]   a_buf,
  input  logic [K-1:0][N-1:0]   b_buf,
  output logic [N-1:0]          arr_in1,
  output logic [N-1:0]          arr_in2
);

  always_comb begin
    arr_in1 = '0;
    arr_in2 = '0;
    if (feed_en) begin
      for (int j = 0; j < N; j++) begin
        for (int k = 0; k < K; k++) begin
          if (int'(beat) == k + j) begin
            arr_in1[j] = a_buf[k][j];
            arr_in2[j] = b_buf[k][j];
          end
        end
      end
    end
  end

endmodule

// File: rtl/systolic_seq.sv
// Job sequencer for the 8x8 boolean systolic array: loads operands, clears,
// feeds skewed wavefronts, flushes, reads back and streams the result rows.
module systolic_seq
  import systolic_pkg::*;
#(
  parameter int N        = N_DEF,
  parameter int K        = K_DEF,
  parameter int FLUSH    = FLUSH_DEF,
  parameter int READ_LAT = READ_LAT_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         abort,
  output logic         busy,
  input  logic [N-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [N-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] arr_in1,
  output logic [N-1:0] arr_in2,
  output logic         arr_clear,
  output logic         arr_readout,
  input  logic [N-1:0] arr_out
);

  localparam int CW = beat_width(N, K, FLUSH, READ_LAT);
  localparam int SW = idx_width(N);
  localparam int KW = idx_width(K);

  localparam logic [CW-1:0] LOAD_LAST  = CW'(2 * K - 1);
  localparam logic [CW-1:0] FEED_LAST  = CW'(K + N - 2);
  localparam logic [CW-1:0] FLUSH_LAST = CW'((FLUSH > 0) ? FLUSH - 1 : 0);
  localparam logic [CW-1:0] READ_FIRST = CW'(READ_LAT);
  localparam logic [CW-1:0] READ_LAST  = CW'(READ_LAT + N - 1);
  localparam logic [CW-1:0] DRAIN_LAST = CW'(N - 1);

  state_t              state;
  logic [CW-1:0]       beat;
  logic                aborting;
  logic [K-1:0][N-1:0] a_buf;
  logic [K-1:0][N-1:0] b_buf;
  logic [N-1:0][N-1:0] res_buf;

  logic [KW-1:0] a_idx;
  logic [KW-1:0] b_idx;
  logic [SW-1:0] cap_idx;
  logic [SW-1:0] cap_slot;
  logic [SW-1:0] slot_nxt;

  assign a_idx    = KW'(beat);
  assign b_idx    = KW'(beat - CW'(K));
  assign cap_idx  = SW'(beat - READ_FIRST);
  assign cap_slot = READOUT_LAST_ROW_FIRST ? cap_idx : SW'(N - 1) - cap_idx;
  assign slot_nxt = SW'(beat + CW'(1));

  systolic_skew #(.N(N), .K(K), .CW(CW)) u_skew (
    .feed_en (state == S_FEED),
    .beat    (beat),
    .a_buf   (a_buf),
    .b_buf   (b_buf),
    .arr_in1 (arr_in1),
    .arr_in2 (arr_in2)
  );

  // Abort routes every active state through one clear cycle so the array never keeps stale partials.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      beat        <= '0;
      aborting    <= 1'b0;
      busy        <= 1'b0;
      in_ready    <= 1'b0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      arr_clear   <= 1'b1;
      arr_readout <= 1'b0;
      a_buf       <= '0;
      b_buf       <= '0;
      res_buf     <= '0;
    end else if (abort && state != S_IDLE) begin
      state       <= S_CLEAR;
      beat        <= '0;
      aborting    <= 1'b1;
      in_ready    <= 1'b0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      arr_clear   <= 1'b1;
      arr_readout <= 1'b0;
      a_buf       <= '0;
      b_buf       <= '0;
      res_buf     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          arr_clear <= 1'b0;
          if (start && !abort) begin
            state    <= S_LOAD;
            beat     <= '0;
            busy     <= 1'b1;
            in_ready <= 1'b1;
          end
        end
        S_LOAD: begin
          if (in_valid) begin
            if (beat < CW'(K)) a_buf[a_idx] <= in_data;
            else               b_buf[b_idx] <= in_data;
            if (beat == LOAD_LAST) begin
              state     <= S_CLEAR;
              beat      <= '0;
              in_ready  <= 1'b0;
              arr_clear <= 1'b1;
            end else begin
              beat <= beat + CW'(1);
            end
          end
        end
        S_CLEAR: begin
          arr_clear <= 1'b0;
          beat      <= '0;
          if (aborting) begin
            state    <= S_IDLE;
            aborting <= 1'b0;
            busy     <= 1'b0;
          end else begin
            state <= S_FEED;
          end
        end
        S_FEED: begin
          if (beat == FEED_LAST) begin
            beat <= '0;
            if (FLUSH == 0) begin
              state       <= S_READ;
              arr_readout <= 1'b1;
            end else begin
              state <= S_FLUSH;
            end
          end else begin
            beat <= beat + CW'(1);
          end
        end
        S_FLUSH: begin
          if (beat == FLUSH_LAST) begin
            state       <= S_READ;
            beat        <= '0;
            arr_readout <= 1'b1;
          end else begin
            beat <= beat + CW'(1);
          end
        end
        // Slot 0 may be the very row captured on the last read beat, so bypass it straight out.
        S_READ: begin
          if (beat >= READ_FIRST) res_buf[cap_slot] <= arr_out;
          if (beat == READ_LAST) begin
            state       <= S_DRAIN;
            beat        <= '0;
            arr_readout <= 1'b0;
            out_valid   <= 1'b1;
            out_data    <= (cap_slot == '0) ? arr_out : res_buf[0];
          end else begin
            beat <= beat + CW'(1);
          end
        end
        S_DRAIN: begin
          if (out_ready) begin
            if (beat == DRAIN_LAST) begin
              state     <= S_IDLE;
              beat      <= '0;
              out_valid <= 1'b0;
              out_data  <= '0;
              busy      <= 1'b0;
            end else begin
              beat     <= beat + CW'(1);
              out_data <= res_buf[slot_nxt];
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_systolic_seq.sv
// Directed bench for systolic_seq with a behavioural boolean array model
// that de-skews the observed wavefronts and serves rows on readout.
module tb_systolic_seq;

  localparam int N        = 8;
  localparam int READ_LAT = 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       busy, in_ready, out_valid, arr_clear, arr_readout;
  logic [7:0] out_data, arr_in1, arr_in2, arr_out;

  int checks = 0;
  int errors = 0;

  systolic_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .busy(busy),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .arr_in1(arr_in1), .arr_in2(arr_in2), .arr_clear(arr_clear),
    .arr_readout(arr_readout), .arr_out(arr_out)
  );

  always #5 clk = ~clk;

  // Array model: history index equals feed beat; product a_k[i]&b_k[j] pairs in1 at k+i with in2 at k+j.
  logic [7:0] hist1 [64];
  logic [7:0] hist2 [64];
  logic [7:0] cmat [8];
  int tcnt = 0;
  int rd_cnt = 0;

  function automatic logic [7:0] model_row(input int i);
    logic [7:0] r;
    r = 8'h00;
    for (int k = 0; k < 32; k++)
      for (int j = 0; j < 8; j++)
        if (hist1[k + i][i] === 1'b1 && hist2[k + j][j] === 1'b1) r[j] = 1'b1;
    return r;
  endfunction

  always @(posedge clk) begin
    if (arr_clear) begin
      tcnt <= 0;
      for (int t = 0; t < 64; t++) begin
        hist1[t] <= 8'h00;
        hist2[t] <= 8'h00;
      end
    end else if (tcnt < 64) begin
      hist1[tcnt] <= arr_in1;
      hist2[tcnt] <= arr_in2;
      tcnt <= tcnt + 1;
    end
    rd_cnt <= arr_readout ? rd_cnt + 1 : 0;
    for (int i = 0; i < 8; i++) cmat[i] <= model_row(i);
  end

  assign arr_out = (arr_readout && rd_cnt >= READ_LAT && rd_cnt < READ_LAT + N)
                   ? cmat[N - 1 - (rd_cnt - READ_LAT)] : 8'h00;

  int clear_cnt = 0;
  int readout_cnt = 0;
  int hs_cnt = 0;
  int ov_cnt = 0;
  int busy_drop = 0;
  bit job_active = 1'b0;

  always @(negedge clk) begin
    if (arr_clear) clear_cnt <= clear_cnt + 1;
    if (arr_readout) readout_cnt <= readout_cnt + 1;
    if (in_valid && in_ready) hs_cnt <= hs_cnt + 1;
    if (out_valid) ov_cnt <= ov_cnt + 1;
    if (job_active && !busy) busy_drop <= busy_drop + 1;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send_start;
    start = 1'b1;
    tick;
    start = 1'b0;
  endtask

  task automatic load_bytes(input logic [15:0][7:0] bytes, input bit gap);
    int idx = 0;
    int cyc = 0;
    bit acc;
    while (idx < 16 && cyc < 200) begin
      in_valid = (gap && (cyc % 2 == 1)) ? 1'b0 : 1'b1;
      in_data = bytes[idx];
      @(negedge clk);
      acc = in_valid && in_ready;
      tick;
      if (acc) idx++;
      cyc++;
    end
    in_valid = 1'b0;
    in_data = 8'h00;
    checks++;
    if (idx != 16) begin
      errors++;
      $display("[TB] FAIL load_count: accepted %0d bytes, expected 16", idx);
    end
  endtask

  task automatic wait_out_valid;
    int cyc = 0;
    while (!out_valid && cyc < 300) begin
      tick;
      cyc++;
    end
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL out_valid_timeout: out_valid=%b after %0d cycles, expected 1", out_valid, cyc);
    end
  endtask

  task automatic drain(input int stall_slot, input int stall_len, output logic [7:0][7:0] res);
    int m = 0;
    int cyc = 0;
    int held = 0;
    logic [7:0] hold_val = 8'h00;
    bit acc;
    res = '0;
    while (m < 8 && cyc < 400) begin
      out_ready = (m == stall_slot && held < stall_len) ? 1'b0 : 1'b1;
      @(negedge clk);
      if (!out_ready) begin
        if (held > 0) begin
          checks++;
          if (out_data !== hold_val || out_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL stall_hold: out_data=%h valid=%b, expected %h valid=1", out_data, out_valid, hold_val);
          end
        end else begin
          hold_val = out_data;
        end
        held++;
      end else if (out_valid) begin
        res[m] = out_data;
      end
      acc = out_valid && out_ready;
      tick;
      if (acc) m++;
      cyc++;
    end
    out_ready = 1'b0;
    checks++;
    if (m != 8) begin
      errors++;
      $display("[TB] FAIL drain_count: drained %0d slots, expected 8", m);
    end
  endtask

  task automatic run_job(input logic [15:0][7:0] bytes, input bit gap, input int stall_slot,
                         input int stall_len, output logic [7:0][7:0] res);
    send_start;
    job_active = 1'b1;
    load_bytes(bytes, gap);
    wait_out_valid;
    drain(stall_slot, stall_len, res);
    job_active = 1'b0;
  endtask

  function automatic logic [15:0][7:0] identity_bytes();
    logic [15:0][7:0] b;
    for (int k = 0; k < 8; k++) begin
      b[k] = 8'h01 << k;
      b[8 + k] = 8'h01 << k;
    end
    return b;
  endfunction

  function automatic logic [15:0][7:0] or_fill_bytes();
    logic [15:0][7:0] b;
    b = '0;
    for (int k = 0; k < 8; k++) b[k] = 8'hFF;
    b[8 + 3] = 8'hA5;
    return b;
  endfunction

  task automatic test_reset;
    logic [28:0] got;
    rst_n = 1'b0;
    tick;
    @(negedge clk);
    got = {busy, in_ready, out_valid, arr_readout, arr_clear, out_data, arr_in1, arr_in2};
    checks++;
    if (got !== {4'b0000, 1'b1, 24'h000000}) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got %h, expected %h", got, {4'b0000, 1'b1, 24'h000000});
    end
    rst_n = 1'b1;
    tick;
    tick;
    checks++;
    if ({arr_clear, busy, in_ready} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL idle_after_reset: clear/busy/ready=%b, expected 000", {arr_clear, busy, in_ready});
    end
  endtask

  task automatic test_identity;
    logic [7:0][7:0] res;
    int c0 = clear_cnt;
    int bd0 = busy_drop;
    run_job(identity_bytes(), 1'b0, -1, 0, res);
    for (int m = 0; m < 8; m++) begin
      logic [7:0] exp;
      exp = 8'h80 >> m;
      checks++;
      if (res[m] !== exp) begin
        errors++;
        $display("[TB] FAIL identity_slot%0d: got %h, expected %h", m, res[m], exp);
      end
    end
    checks++;
    if (clear_cnt - c0 != 1) begin
      errors++;
      $display("[TB] FAIL identity_clear_count: got %0d, expected 1", clear_cnt - c0);
    end
    checks++;
    if (busy_drop - bd0 != 0) begin
      errors++;
      $display("[TB] FAIL identity_busy: busy low %0d cycles mid-job, expected 0", busy_drop - bd0);
    end
    checks++;
    if ({out_valid, busy} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL identity_end: valid/busy=%b, expected 00", {out_valid, busy});
    end
  endtask

  task automatic test_or_fill;
    logic [7:0][7:0] res;
    int r0 = readout_cnt;
    run_job(or_fill_bytes(), 1'b0, -1, 0, res);
    for (int m = 0; m < 8; m++) begin
      checks++;
      if (res[m] !== 8'hA5) begin
        errors++;
        $display("[TB] FAIL or_fill_slot%0d: got %h, expected a5", m, res[m]);
      end
    end
    checks++;
    if (readout_cnt - r0 != 9) begin
      errors++;
      $display("[TB] FAIL readout_cycles: got %0d, expected 9", readout_cnt - r0);
    end
  endtask

  task automatic test_back_to_back_stall;
    logic [15:0][7:0] bytes;
    logic [7:0][7:0] res_u;
    logic [7:0][7:0] res_s;
    logic [7:0] bvals [8];
    int h0;
    bvals = '{8'h11, 8'h22, 8'h44, 8'h88, 8'h01, 8'h02, 8'h04, 8'h08};
    for (int k = 0; k < 8; k++) begin
      bytes[k] = (k < 4) ? 8'h0F : 8'hF0;
      bytes[8 + k] = bvals[k];
    end
    run_job(bytes, 1'b0, -1, 0, res_u);
    h0 = hs_cnt;
    run_job(bytes, 1'b1, 2, 5, res_s);
    checks++;
    if (hs_cnt - h0 != 16) begin
      errors++;
      $display("[TB] FAIL stall_handshakes: got %0d, expected 16", hs_cnt - h0);
    end
    for (int m = 0; m < 8; m++) begin
      logic [7:0] exp;
      exp = (m < 4) ? 8'h0F : 8'hFF;
      checks++;
      if (res_u[m] !== exp) begin
        errors++;
        $display("[TB] FAIL unstalled_slot%0d: got %h, expected %h", m, res_u[m], exp);
      end
      checks++;
      if (res_s[m] !== exp) begin
        errors++;
        $display("[TB] FAIL stalled_slot%0d: got %h, expected %h", m, res_s[m], exp);
      end
    end
  endtask

  task automatic test_abort;
    logic [7:0][7:0] res;
    int c0;
    int v0;
    send_start;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data = 8'(i + 1);
      tick;
    end
    in_valid = 1'b0;
    c0 = clear_cnt;
    v0 = ov_cnt;
    abort = 1'b1;
    tick;
    abort = 1'b0;
    @(negedge clk);
    checks++;
    if ({arr_clear, busy, in_ready} !== 3'b110) begin
      errors++;
      $display("[TB] FAIL abort_clear: clear/busy/ready=%b, expected 110", {arr_clear, busy, in_ready});
    end
    tick;
    @(negedge clk);
    checks++;
    if ({arr_clear, busy, in_ready, out_valid} !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL abort_idle: clear/busy/ready/valid=%b, expected 0000",
               {arr_clear, busy, in_ready, out_valid});
    end
    repeat (10) tick;
    checks++;
    if (clear_cnt - c0 != 1) begin
      errors++;
      $display("[TB] FAIL abort_clear_count: got %0d, expected 1", clear_cnt - c0);
    end
    checks++;
    if (ov_cnt - v0 != 0) begin
      errors++;
      $display("[TB] FAIL abort_out_valid: high %0d cycles, expected 0", ov_cnt - v0);
    end
    run_job(identity_bytes(), 1'b0, -1, 0, res);
    for (int m = 0; m < 8; m++) begin
      logic [7:0] exp;
      exp = 8'h80 >> m;
      checks++;
      if (res[m] !== exp) begin
        errors++;
        $display("[TB] FAIL after_abort_slot%0d: got %h, expected %h", m, res[m], exp);
      end
    end
  endtask

  task automatic test_async_reset;
    logic [7:0][7:0] res;
    logic [12:0] got;
    int cyc = 0;
    send_start;
    load_bytes(identity_bytes(), 1'b0);
    @(negedge clk);
    while (!arr_clear && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    repeat (3) tick;
    checks++;
    if ({arr_in1, arr_in2} !== 16'h0202) begin
      errors++;
      $display("[TB] FAIL feed_beat2: in1/in2=%h, expected 0202", {arr_in1, arr_in2});
    end
    #2;
    rst_n = 1'b0;
    #1;
    got = {busy, in_ready, out_valid, arr_readout, arr_clear, out_data};
    checks++;
    if (got !== {4'b0000, 1'b1, 8'h00} || {arr_in1, arr_in2} !== 16'h0000) begin
      errors++;
      $display("[TB] FAIL async_reset: ctl=%h in=%h, expected %h 0000",
               got, {arr_in1, arr_in2}, {4'b0000, 1'b1, 8'h00});
    end
    tick;
    rst_n = 1'b1;
    tick;
    tick;
    run_job(or_fill_bytes(), 1'b0, -1, 0, res);
    for (int m = 0; m < 8; m++) begin
      checks++;
      if (res[m] !== 8'hA5) begin
        errors++;
        $display("[TB] FAIL after_reset_slot%0d: got %h, expected a5", m, res[m]);
      end
    end
  endtask

  task automatic test_ignored_inputs;
    logic [7:0][7:0] res;
    int cyc = 0;
    in_valid = 1'b1;
    in_data = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({in_ready, busy} !== 2'b00) begin
        errors++;
        $display("[TB] FAIL idle_in_valid: ready/busy=%b, expected 00", {in_ready, busy});
      end
      tick;
    end
    in_valid = 1'b0;
    send_start;
    load_bytes(identity_bytes(), 1'b0);
    while (!arr_readout && cyc < 100) begin
      tick;
      cyc++;
    end
    start = 1'b1;
    in_valid = 1'b1;
    in_data = 8'h55;
    @(negedge clk);
    checks++;
    if ({arr_readout, in_ready} !== 2'b10) begin
      errors++;
      $display("[TB] FAIL read_in_ready: readout/ready=%b, expected 10", {arr_readout, in_ready});
    end
    tick;
    start = 1'b0;
    in_valid = 1'b0;
    wait_out_valid;
    drain(-1, 0, res);
    for (int m = 0; m < 8; m++) begin
      logic [7:0] exp;
      exp = 8'h80 >> m;
      checks++;
      if (res[m] !== exp) begin
        errors++;
        $display("[TB] FAIL ignored_slot%0d: got %h, expected %h", m, res[m], exp);
      end
    end
    tick;
    tick;
    checks++;
    if ({busy, in_ready} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL start_in_read_ignored: busy/ready=%b, expected 00", {busy, in_ready});
    end
  endtask

  initial begin
    test_reset;
    test_identity;
    test_or_fill;
    test_back_to_back_stall;
    test_abort;
    test_async_reset;
    test_ignored_inputs;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
